ahb_can_mailbox_slave: RTL and testbench

AHB slave that terminates one arbiter slave port (the 16'hf00x windows) and gives a CAN node core a bus-visible mailbox. It contains a control/status register pair, a TX FIFO written by bus masters and drained by the CAN core, and an RX FIFO filled by the CAN core and drained by bus reads. Every access completes with programmable wait states. Illegal accesses get a two-cycle AHB ERROR response.

---
 rtl/ahb_can_mailbox_slave.sv | 201 ++++++++++++++++++++
 tb/tb_ahb_can_mailbox_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_can_mailbox_slave.sv
// AHB slave mailbox for a CAN node core: CTRL/STATUS registers, a bus-written TX FIFO
// and a core-written RX FIFO, with programmable wait states and two-cycle ERROR responses.
module ahb_can_mailbox_slave #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [15:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_push
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 32;
  localparam logic [2:0]    WS       = 3'(WAIT_STATES);
  localparam bit            HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [2:0]    A_CTRL   = 3'd0;
  localparam logic [2:0]    A_STAT   = 3'd1;
  localparam logic [2:0]    A_TXD    = 3'd2;
  localparam logic [2:0]    A_RXD    = 3'd3;
  localparam logic [1:0]    RESP_OKAY  = 2'b00;
  localparam logic [1:0]    RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e          state_q, state_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic            dp_q, dp_d;
  logic [2:0]      addr_q, addr_d;
  logic            write_q, write_d;
  logic            ctrl_en_q, ctrl_en_d;
  logic            ovf_q, ovf_d;
  logic            hready_q, hready_d;
  logic [1:0]      hresp_q, hresp_d;
  logic [DW-1:0]   hrdata_q, hrdata_d;
  logic            tx_valid_q, tx_valid_d;
  logic [AW-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [AW-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [DW-1:0]   tx_mem [DEPTH];
  logic [DW-1:0]   rx_mem [DEPTH];

  logic            complete, do_ctrl_wr, do_tx_push, do_rx_pop;
  logic            tx_pop, rx_full, rx_wr_en, accept, acc_err, en_chk;
  logic [2:0]      sel;
  logic [CW-1:0]   tx_cnt_chk, rx_cnt_chk;
  logic            unused_bits;

  assign unused_bits = ^{HADDR[15:5], HADDR[1:0], HTRANS[0]};

  always_comb begin
    complete   = dp_q && (state_q == S_IDLE);
    do_ctrl_wr = complete && write_q && (addr_q == A_CTRL);
    do_tx_push = complete && write_q && (addr_q == A_TXD);
    do_rx_pop  = complete && !write_q && (addr_q == A_RXD);
    tx_pop     = tx_valid_q && tx_ready;
    rx_full    = (rx_cnt_q == FULL);
    rx_wr_en   = rx_push && (!rx_full || do_rx_pop);
    accept     = HSEL && HTRANS[1] && hready_q;
    sel        = HADDR[4:2];

    // Error decision accounts for a data phase completing at this same edge.
    en_chk     = do_ctrl_wr ? HWDATA[0] : ctrl_en_q;
    tx_cnt_chk = tx_cnt_q + CW'(do_tx_push);
    rx_cnt_chk = rx_cnt_q - CW'(do_rx_pop);
    acc_err    = 1'b1;
    case (sel)
      A_CTRL:  acc_err = 1'b0;
      A_STAT:  acc_err = HWRITE;
      A_TXD:   acc_err = !HWRITE || !en_chk || (tx_cnt_chk == FULL);
      A_RXD:   acc_err = HWRITE || !en_chk || (rx_cnt_chk == '0);
      default: acc_err = 1'b1;
    endcase
  end

  // Transfer FSM next state.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    dp_d    = dp_q && !complete;
    addr_d  = addr_q;
    write_d = write_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          addr_d  = sel;
          write_d = HWRITE;
          if (acc_err) begin
            state_d = S_ERR1;
          end else begin
            dp_d = 1'b1;
            if (HAS_WAIT) begin
              state_d = S_WAIT;
              wcnt_d  = WS;
            end
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 3'd1) state_d = S_IDLE;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    hready_d = (state_d == S_IDLE) || (state_d == S_ERR2);
    hresp_d  = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
  end

  // Register and FIFO bookkeeping; side effects only at the completion edge.
  always_comb begin
    ctrl_en_d  = do_ctrl_wr ? HWDATA[0] : ctrl_en_q;
    ovf_d      = (ovf_q && !(do_ctrl_wr && HWDATA[1])) || (rx_push && rx_full && !do_rx_pop);
    tx_wr_d    = tx_wr_q + AW'(do_tx_push);
    tx_rd_d    = tx_rd_q + AW'(tx_pop);
    tx_cnt_d   = tx_cnt_q + CW'(do_tx_push) - CW'(tx_pop);
    tx_valid_d = (tx_cnt_d != '0);
    rx_wr_d    = rx_wr_q + AW'(rx_wr_en);
    rx_rd_d    = rx_rd_q + AW'(do_rx_pop);
    rx_cnt_d   = rx_cnt_q + CW'(rx_wr_en) - CW'(do_rx_pop);

    // Read data is loaded on the edge that starts a read's completion cycle.
    hrdata_d = '0;
    if (dp_d && (state_d == S_IDLE) && !write_d) begin
      case (addr_d)
        A_CTRL:  hrdata_d = 32'(ctrl_en_d);
        A_STAT:  hrdata_d = {13'd0, ovf_d, (rx_cnt_d == '0), (tx_cnt_d == FULL),
                             8'(rx_cnt_d), 8'(tx_cnt_d)};
        A_RXD:   hrdata_d = rx_mem[rx_rd_d];
        default: hrdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      dp_q       <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      ctrl_en_q  <= 1'b0;
      ovf_q      <= 1'b0;
      hready_q   <= 1'b1;
      hresp_q    <= RESP_OKAY;
      hrdata_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      dp_q       <= dp_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      ctrl_en_q  <= ctrl_en_d;
      ovf_q      <= ovf_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      hrdata_q   <= hrdata_d;
      tx_valid_q <= tx_valid_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  // FIFO storage is plain RAM, not reset.
  always_ff @(posedge HCLK) begin
    if (do_tx_push) tx_mem[tx_wr_q] <= HWDATA;
    if (rx_wr_en)   rx_mem[rx_wr_q] <= rx_data;
  end

  assign HREADY   = hready_q;
  assign HRESP    = hresp_q;
  assign HRDATA   = hrdata_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_mem[tx_rd_q];

endmodule

// File: tb/tb_ahb_can_mailbox_slave.sv
// Bench for ahb_can_mailbox_slave: directed plan steps plus randomized bus/core traffic
// checked against a queue-based mailbox model.
module tb_ahb_can_mailbox_slave;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WS    = 3;

  logic        clk = 1'b0;
  logic        HRESET, HSEL, hsel0, HWRITE, tx_ready, rx_push;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, rx_data;
  logic [31:0] HRDATA, tx_data, HRDATA0, tx_data0;
  logic        HREADY, tx_valid, HREADY0, tx_valid0;
  logic [1:0]  HRESP, HRESP0;

  logic [31:0] txq [$];
  logic [31:0] rxq [$];
  bit          m_en, m_ovf;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ahb_can_mailbox_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_push(rx_push)
  );

  ahb_can_mailbox_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA0), .HREADY(HREADY0), .HRESP(HRESP0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(1'b0),
    .rx_data(32'd0), .rx_push(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = 32'd0;
    s[7:0]   = 8'(txq.size());
    s[15:8]  = 8'(rxq.size());
    s[16]    = (txq.size() == int'(DEPTH));
    s[17]    = (rxq.size() == 0);
    s[18]    = m_ovf;
    return s;
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_en  = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Register-level effect of one bus access; returns error flag and read value.
  task automatic model_xfer(input logic [15:0] a, input bit w, input logic [31:0] wd,
                            output bit err, output logic [31:0] rd);
    logic [2:0] r;
    r   = a[4:2];
    err = 1'b0;
    rd  = 32'd0;
    case (r)
      3'd0: if (w) begin m_en = wd[0]; if (wd[1]) m_ovf = 1'b0; end
            else rd = {31'd0, m_en};
      3'd1: if (w) err = 1'b1; else rd = model_status();
      3'd2: if (!w || !m_en || txq.size() == int'(DEPTH)) err = 1'b1; else txq.push_back(wd);
      3'd3: if (w || !m_en || rxq.size() == 0) err = 1'b1; else rd = rxq.pop_front();
      default: err = 1'b1;
    endcase
  endtask

  task automatic xfer(input logic [15:0] a, input bit w, input logic [31:0] wd,
                      input bit pop_at_end, input string tag);
    bit          e;
    logic [31:0] rd;
    int          n;
    @(negedge clk);
    HSEL = 1'b1; HADDR = a; HWRITE = w; HTRANS = 2'b10;
    chk({tag, "_addr_ready"}, 32'(HREADY), 32'd1);
    @(posedge clk);
    model_xfer(a, w, wd, e, rd);
    @(negedge clk);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    n = 1;
    while (HREADY !== 1'b1 && n < 16) begin
      chk({tag, "_wait_resp"}, 32'(HRESP), e ? 32'd1 : 32'd0);
      chk({tag, "_wait_rdata"}, HRDATA, 32'd0);
      @(negedge clk);
      n++;
    end
    chk({tag, "_ncycles"}, 32'(n), e ? 32'd2 : 32'(WS + 1));
    chk({tag, "_resp"}, 32'(HRESP), e ? 32'd1 : 32'd0);
    chk({tag, "_rdata"}, HRDATA, (e || w) ? 32'd0 : rd);
    if (pop_at_end && txq.size() > 0) begin
      chk({tag, "_pop_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_pop_data"}, tx_data, txq[0]);
      tx_ready = 1'b1;
    end
    @(posedge clk);
    if (tx_ready) void'(txq.pop_front());
    #1 tx_ready = 1'b0;
  endtask

  task automatic core_op(input bit pop, input bit push, input logic [31:0] d);
    @(negedge clk);
    if (pop) begin
      if (txq.size() > 0) begin
        chk("core_tx_valid", 32'(tx_valid), 32'd1);
        chk("core_tx_data", tx_data, txq[0]);
      end else begin
        chk("core_tx_empty", 32'(tx_valid), 32'd0);
      end
    end
    tx_ready = pop; rx_push = push; rx_data = d;
    @(posedge clk);
    if (pop && txq.size() > 0) void'(txq.pop_front());
    if (push) begin
      if (rxq.size() < int'(DEPTH)) rxq.push_back(d);
      else m_ovf = 1'b1;
    end
    #1 tx_ready = 1'b0; rx_push = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [31:0] wd;
    bit          w;
    int          k;
    HRESET = 1'b1; HSEL = 1'b0; hsel0 = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00;
    HWDATA = '0; tx_ready = 1'b0; rx_push = 1'b0; rx_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_hready0", 32'(HREADY0), 32'd1);
    HRESET = 1'b0;

    // Load some state, then reset one cycle into a waited data phase.
    xfer(16'h0000, 1'b1, 32'h1, 1'b0, "en");
    xfer(16'h0008, 1'b1, 32'hDEAD_0000, 1'b0, "prepush");
    @(negedge clk);
    HSEL = 1'b1; HADDR = 16'h0004; HWRITE = 1'b0; HTRANS = 2'b10;
    @(posedge clk);
    @(negedge clk);
    HSEL = 1'b0; HTRANS = 2'b00;
    chk("midwait_hready", 32'(HREADY), 32'd0);
    HRESET = 1'b1;
    #1;
    chk("midrst_hready", 32'(HREADY), 32'd1);
    chk("midrst_hresp", 32'(HRESP), 32'd0);
    chk("midrst_hrdata", HRDATA, 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    model_reset();
    @(negedge clk);
    HRESET = 1'b0;
    xfer(16'h0004, 1'b0, 32'd0, 1'b0, "status_after_rst");

    // TX fill to full, overflow push errors.
    xfer(16'h0000, 1'b1, 32'h1, 1'b0, "ctrl_en");
    for (int i = 1; i <= 4; i++) xfer(16'h0008, 1'b1, 32'hA5A5_0000 + 32'(i), 1'b0, "txpush");
    xfer(16'h0004, 1'b0, 32'd0, 1'b0, "status_txfull");
    xfer(16'h0008, 1'b1, 32'hA5A5_0005, 1'b0, "txpush_full");
    xfer(16'h0004, 1'b0, 32'd0, 1'b0, "status_txfull2");

    // Core drains TX in order.
    for (int i = 0; i < 4; i++) core_op(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("tx_drained", 32'(tx_valid), 32'd0);

    // RX overflow, reads, underflow error, RX_OVF clear.
    for (int i = 1; i <= 5; i++) core_op(1'b0, 1'b1, 32'h1111 * 32'(i));
    xfer(16'h0004, 1'b0, 32'd0, 1'b0, "status_rxovf");
    for (int i = 0; i < 4; i++) xfer(16'h000C, 1'b0, 32'd0, 1'b0, "rxread");
    xfer(16'h000C, 1'b0, 32'd0, 1'b0, "rxread_empty");
    xfer(16'h0000, 1'b1, 32'h3, 1'b0, "ovf_clear");
    xfer(16'h0004, 1'b0, 32'd0, 1'b0, "status_ovf_clr");

    // Disabled accesses, unmapped offset, push with simultaneous pop.
    xfer(16'h0000, 1'b1, 32'h0, 1'b0, "ctrl_dis");
    xfer(16'h0008, 1'b1, 32'h1234, 1'b0, "tx_disabled");
    xfer(16'h0010, 1'b0, 32'd0, 1'b0, "unmapped");
    xfer(16'h0000, 1'b0, 32'd0, 1'b0, "ctrl_read");
    xfer(16'h0000, 1'b1, 32'h1, 1'b0, "ctrl_en2");
    for (int i = 0; i < 3; i++) xfer(16'h0008, 1'b1, 32'hB000_0000 + 32'(i), 1'b0, "txpush3");
    xfer(16'h0008, 1'b1, 32'hB000_0003, 1'b1, "push_pop");
    xfer(16'h0004, 1'b0, 32'd0, 1'b0, "status_pushpop");
    chk("pushpop_count", 32'(txq.size()), 32'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      if (k < 2) begin
        core_op(1'b1, 1'b0, 32'd0);
      end else if (k < 4) begin
        core_op(1'b0, 1'b1, $urandom);
      end else if (k == 4) begin
        core_op(1'b1, 1'b1, $urandom);
      end else begin
        a  = 16'($urandom_range(0, 7) * 4);
        w  = 1'($urandom_range(0, 1));
        wd = $urandom;
        if (a == 16'h0000 && w) wd[0] = ($urandom_range(0, 4) != 0);
        xfer(a, w, wd, 1'b0, "rnd");
      end
    end

    // Zero-wait instance: TXDATA write then SEQ STATUS read back to back.
    @(negedge clk);
    hsel0 = 1'b1; HADDR = 16'h0000; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge clk);
    @(negedge clk);
    hsel0 = 1'b0; HTRANS = 2'b00; HWDATA = 32'h1;
    chk("b2b_ctrl_ready", 32'(HREADY0), 32'd1);
    chk("b2b_ctrl_resp", 32'(HRESP0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    hsel0 = 1'b1; HADDR = 16'h0008; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge clk);
    @(negedge clk);
    HADDR = 16'h0004; HWRITE = 1'b0; HTRANS = 2'b11; HWDATA = 32'hCAFE_0001;
    chk("b2b_push_ready", 32'(HREADY0), 32'd1);
    chk("b2b_push_resp", 32'(HRESP0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    hsel0 = 1'b0; HTRANS = 2'b00;
    chk("b2b_read_ready", 32'(HREADY0), 32'd1);
    chk("b2b_read_resp", 32'(HRESP0), 32'd0);
    chk("b2b_read_status", HRDATA0, 32'h0002_0001);
    chk("b2b_tx_valid", 32'(tx_valid0), 32'd1);
    chk("b2b_tx_data", tx_data0, 32'hCAFE_0001);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_rdata_idle", HRDATA0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
